// File: rtl/pkt_cell_reader_if.sv
// Handshake bundle for the cell-chain reader: descriptor in,
// block-memory read port, byte stream out and free-list return.
interface pkt_cell_reader_if #(
  parameter int BLOCK_BYTES = 64,
  parameter int ADDR_W      = 12,
  parameter int LEN_W       = 16
);
  logic                     desc_valid;
  logic                     desc_ready;
  logic [ADDR_W-1:0]        desc_head;
  logic [LEN_W-1:0]         desc_len;

  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [BLOCK_BYTES*8-1:0] mem_rd_data;

  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic                     out_last;

  logic                     free_valid;
  logic                     free_ready;
  logic [ADDR_W-1:0]        free_idx;

  logic                     err;

  modport master (
    input  desc_valid,
    input  desc_head,
    input  desc_len,
    output desc_ready,
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output free_valid,
    input  free_ready,
    output free_idx,
    output err
  );

  modport slave (
    output desc_valid,
    output desc_head,
    output desc_len,
    input  desc_ready,
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  free_valid,
    output free_ready,
    input  free_idx,
    input  err
  );
endinterface

// File: rtl/pkt_cell_reader.sv
// Egress cell-chain reader: walks linked cells from block memory,
// streams payload bytes and returns consumed cells to the free list.
package mem_pkg;
  localparam int MEM_BLOCK_BYTES = 64;
  localparam int MEM_NUM_BLOCKS  = 4096;
  localparam int MEM_ADDR_W      = $clog2(MEM_NUM_BLOCKS);

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] next_idx;
    logic                  eop;
    logic [2:0]            rsvd;
  } footer_t;

  localparam int MEM_FOOTER_BYTES = $bits(footer_t) / 8;
endpackage

module pkt_cell_reader
  import mem_pkg::*;
#(
  parameter int BLOCK_BYTES  = MEM_BLOCK_BYTES,
  parameter int NUM_BLOCKS   = MEM_NUM_BLOCKS,
  parameter int FOOTER_BYTES = MEM_FOOTER_BYTES,
  parameter int LEN_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  pkt_cell_reader_if.master bus
);

  localparam int ADDR_W        = $clog2(NUM_BLOCKS);
  localparam int PAYLOAD_BYTES = BLOCK_BYTES - FOOTER_BYTES;
  localparam int IDX_W         = $clog2(PAYLOAD_BYTES);
  localparam int FTR_W         = $bits(footer_t);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM,
    FREE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_idx;
  logic [ADDR_W-1:0] next_idx;
  logic [LEN_W-1:0]  remaining;
  logic [IDX_W-1:0]  cell_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic              last_cell;
  logic [7:0]        cell_buf [PAYLOAD_BYTES];

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic              out_last_q;
  logic              free_valid_q;
  logic [ADDR_W-1:0] free_idx_q;
  logic              err_q;

  footer_t           ftr;
  logic              fits;
  logic [IDX_W-1:0]  ld_cnt;
  logic              ld_last;
  logic [IDX_W-1:0]  nxt_b;
  logic              cell_end;
  logic              nxt_is_last;

  assign ftr = footer_t'(bus.mem_rd_data[BLOCK_BYTES*8-1 -: FTR_W]);

  // A cell is the last one either because the length runs out here
  // or because the chain says so; disagreement between them is an error.
  assign fits    = remaining <= LEN_W'(PAYLOAD_BYTES);
  assign ld_cnt  = fits ? remaining[IDX_W-1:0]
                        : IDX_W'(PAYLOAD_BYTES);
  assign ld_last = fits | ftr.eop;

  assign nxt_b       = byte_idx + IDX_W'(1);
  assign cell_end    = byte_idx == cell_cnt - IDX_W'(1);
  assign nxt_is_last = last_cell
                     & (nxt_b == cell_cnt - IDX_W'(1));

  assign bus.desc_ready  = state == IDLE;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.free_valid  = free_valid_q;
  assign bus.free_idx    = free_idx_q;
  assign bus.err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_idx      <= '0;
      next_idx     <= '0;
      remaining    <= '0;
      cell_cnt     <= '0;
      byte_idx     <= '0;
      last_cell    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < PAYLOAD_BYTES; i++)
        cell_buf[i] <= '0;
    end else begin
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.desc_valid) begin
            if (bus.desc_len == '0) begin
              err_q <= 1'b1;
            end else begin
              cur_idx   <= bus.desc_head;
              remaining <= bus.desc_len;
              rd_en_q   <= 1'b1;
              rd_addr_q <= bus.desc_head;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < PAYLOAD_BYTES; i++)
            cell_buf[i] <= bus.mem_rd_data[8*i +: 8];
          next_idx    <= ftr.next_idx;
          cell_cnt    <= ld_cnt;
          byte_idx    <= '0;
          last_cell   <= ld_last;
          err_q       <= fits ^ ftr.eop;
          out_valid_q <= 1'b1;
          out_data_q  <= bus.mem_rd_data[7:0];
          out_last_q  <= ld_last & (ld_cnt == IDX_W'(1));
          state       <= STREAM;
        end
        STREAM: begin
          if (bus.out_ready) begin
            remaining <= remaining - LEN_W'(1);
            if (cell_end) begin
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              free_valid_q <= 1'b1;
              free_idx_q   <= cur_idx;
              state        <= FREE;
            end else begin
              byte_idx   <= nxt_b;
              out_data_q <= cell_buf[nxt_b];
              out_last_q <= nxt_is_last;
            end
          end
        end
        FREE: begin
          if (bus.free_ready) begin
            free_valid_q <= 1'b0;
            if (last_cell) begin
              state <= IDLE;
            end else begin
              cur_idx   <= next_idx;
              rd_en_q   <= 1'b1;
              rd_addr_q <= next_idx;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_cell_reader.sv
// Directed bench for pkt_cell_reader: block-memory model,
// stream/free/read monitors and hand-built cell chains.
module tb_pkt_cell_reader;
  localparam int BB = 64;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int PB = 62;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_cell_reader_if #(
    .BLOCK_BYTES(BB),
    .ADDR_W(AW),
    .LEN_W(LW)
  ) bus ();

  pkt_cell_reader dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [BB*8-1:0] mem [4096];

  always @(posedge clk)
    if (bus.mem_rd_en)
      bus.mem_rd_data <= mem[bus.mem_rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(int c, int i);
    return 8'(c * 3 + i + 16);
  endfunction

  task automatic set_cell(int idx, int nxt, bit eop);
    logic [BB*8-1:0] w;
    w = '0;
    for (int i = 0; i < PB; i++)
      w[8*i +: 8] = pat(idx, i);
    w[BB*8-1 -: 16] = {12'(nxt), eop, 3'b101};
    mem[idx] = w;
  endtask

  logic [7:0] got_d [$];
  bit         got_l [$];
  int         reads [$];
  int         frees [$];
  int         exp_chain [$];
  int         err_cnt = 0;
  int         cyc = 0;
  int         t_acc, t_rd, t_out;
  bit         rd_seen, out_seen;
  bit         pv_o, pv_f, pv_l;
  logic [7:0] pv_d;
  logic [AW-1:0] pv_fi;
  bit         stall_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv_o = 0;
      pv_f = 0;
    end else begin
      if (pv_o) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, pv_d);
        check("hold_last", bus.out_last, pv_l);
      end
      if (pv_f) begin
        check("hold_fvalid", bus.free_valid, 1);
        check("hold_fidx", bus.free_idx, pv_fi);
      end
      pv_o  = bus.out_valid && !bus.out_ready;
      pv_d  = bus.out_data;
      pv_l  = bus.out_last;
      pv_f  = bus.free_valid && !bus.free_ready;
      pv_fi = bus.free_idx;
      if (bus.desc_valid && bus.desc_ready) begin
        t_acc = cyc;
        rd_seen = 0;
        out_seen = 0;
      end
      if (bus.mem_rd_en) begin
        reads.push_back(int'(bus.mem_rd_addr));
        if (!rd_seen) begin
          t_rd = cyc;
          rd_seen = 1;
        end
      end
      if (bus.out_valid && !out_seen) begin
        t_out = cyc;
        out_seen = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
      if (bus.free_valid && bus.free_ready)
        frees.push_back(int'(bus.free_idx));
      if (bus.err) err_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        bus.out_ready  = 1'($urandom_range(0, 1));
        bus.free_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.out_ready  = 1'b1;
        bus.free_ready = 1'b1;
      end
    end
  end

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    reads.delete();
    frees.delete();
    err_cnt = 0;
  endtask

  task automatic send_desc(int head, int len);
    int k;
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b1;
    bus.desc_head  = AW'(head);
    bus.desc_len   = LW'(len);
    @(negedge clk);
    k = 0;
    while (!bus.desc_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("desc_timeout", k, 0);
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.desc_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("done_timeout", k, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stream(int nbytes, int last_pos);
    int nl, lp;
    check("nbytes", got_d.size(), nbytes);
    for (int k = 0; k < got_d.size() && k < nbytes; k++)
      check("byte", got_d[k], pat(exp_chain[k / PB], k % PB));
    nl = 0;
    lp = -1;
    foreach (got_l[k])
      if (got_l[k]) begin
        nl++;
        lp = k;
      end
    check("last_cnt", nl, 1);
    check("last_pos", lp, last_pos);
    check("nreads", reads.size(), exp_chain.size());
    for (int k = 0; k < reads.size() && k < exp_chain.size(); k++)
      check("read_addr", reads[k], exp_chain[k]);
    check("nfrees", frees.size(), exp_chain.size());
    for (int k = 0; k < frees.size() && k < exp_chain.size(); k++)
      check("free_idx", frees[k], exp_chain[k]);
  endtask

  task automatic run_short();
    clear_mon();
    exp_chain = '{5};
    send_desc(5, 10);
    wait_done();
    check_stream(10, 9);
    check("err_short", err_cnt, 0);
    check("lat_rd", t_rd - t_acc, 1);
    check("lat_out", t_out - t_acc, 3);
  endtask

  task automatic run_130();
    clear_mon();
    exp_chain = '{7, 12, 3};
    send_desc(7, 130);
    wait_done();
    check_stream(130, 129);
    check("err_130", err_cnt, 0);
  endtask

  initial begin
    int k;
    bus.desc_valid = 1'b0;
    bus.desc_head  = '0;
    bus.desc_len   = '0;
    bus.out_ready  = 1'b1;
    bus.free_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    set_cell(5, 9, 1);
    set_cell(7, 12, 0);
    set_cell(12, 3, 0);
    set_cell(3, 0, 1);
    set_cell(20, 21, 1);
    set_cell(30, 31, 0);
    set_cell(31, 0, 1);
    set_cell(40, 41, 1);
    set_cell(50, 51, 0);

    repeat (3) @(negedge clk);
    check("rst_desc_ready", bus.desc_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_free_valid", bus.free_valid, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_short();
    run_130();

    clear_mon();
    exp_chain = '{20};
    send_desc(20, 62);
    wait_done();
    check_stream(62, 61);
    check("err_62", err_cnt, 0);

    clear_mon();
    exp_chain = '{30, 31};
    send_desc(30, 124);
    wait_done();
    check_stream(124, 123);
    check("err_124", err_cnt, 0);

    stall_mode = 1;
    run_130();
    stall_mode = 0;
    repeat (2) @(negedge clk);

    clear_mon();
    exp_chain = '{40};
    send_desc(40, 70);
    wait_done();
    check_stream(62, 61);
    check("err_trunc", err_cnt, 1);

    clear_mon();
    exp_chain = '{50};
    send_desc(50, 10);
    wait_done();
    check_stream(10, 9);
    check("err_noeop", err_cnt, 1);

    clear_mon();
    send_desc(9, 0);
    wait_done();
    check("len0_err", err_cnt, 1);
    check("len0_reads", reads.size(), 0);
    check("len0_bytes", got_d.size(), 0);
    check("len0_ready", bus.desc_ready, 1);

    clear_mon();
    send_desc(7, 130);
    k = 0;
    while (got_d.size() < 30 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) check("mid_timeout", k, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_out_last", bus.out_last, 0);
    check("arst_rd_en", bus.mem_rd_en, 0);
    check("arst_free_valid", bus.free_valid, 0);
    check("arst_err", bus.err, 0);
    check("arst_desc_ready", bus.desc_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.desc_ready, 1);
    run_short();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
